cell_to_frame: RTL and testbench

- Egress reassembler for one output port.
- Accepts 128-bit cells from the switch core (one bit of o_cell_fifo_wr per port; one instance per port) and buffers them in an internal word FIFO.
- Unpacks each frame into an 8-bit byte stream plus a 16-bit frame descriptor for the TX MAC.
- Mirror of the ingress sfifo/ptr_sfifo path feeding frame_process.

---
 rtl/cell_to_frame.sv | 238 +++++++++++++++++++++++
 tb/tb_cell_to_frame.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_to_frame.sv
// Egress reassembler: buffers 128-bit switch cells and unpacks them into a byte stream plus frame descriptor.
// Optional statistics counters are built when CELL_TO_FRAME_STATS_EN is defined.
//
// state   | meaning
// S_IDLE  | wait for a header word; discard orphan payload words
// S_DATA  | unpack payload words into bytes, MSB byte first
// S_DRAIN | discard words up to the frame's last word
// S_PTR   | write the descriptor {err, 4'b0, written_count}
module cell_to_frame #(
    parameter int DEPTH     = 16,
    parameter int BP_MARGIN = 8,
    parameter int MAX_LEN   = 1536
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         cell_wr,
    input  logic [127:0] cell_din,
    input  logic         cell_first,
    input  logic         cell_last,
    output logic         cell_bp,
    output logic [7:0]   data_fifo_din,
    output logic         data_fifo_wr,
    input  logic         data_fifo_afull,
    output logic [15:0]  ptr_fifo_din,
    output logic         ptr_fifo_wr,
    input  logic         ptr_fifo_full
`ifdef CELL_TO_FRAME_STATS_EN
    ,
    output logic [31:0]  frame_cnt,
    output logic [15:0]  err_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0] BP_W      = (AW+1)'(BP_MARGIN);
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_DRAIN, S_PTR} state_t;

    logic [129:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr, r_rd_ptr;
    logic         r_cell_bp;
    logic [AW:0]  w_count, w_free;
    logic         w_full, w_hd_valid, w_push, w_pop, w_drop;
    logic [129:0] w_head;
    logic         w_hd_first, w_hd_last;
    logic [127:0] w_hd_data;

    state_t       r_state, w_state_nxt;
    logic [127:0] r_shift, w_shift_nxt;
    logic [4:0]   r_left, w_left_nxt;
    logic         r_word_last, w_word_last_nxt;
    logic [10:0]  r_len, w_len_nxt;
    logic [10:0]  r_cnt, w_cnt_nxt;
    logic         r_err, w_err_nxt;
    logic         r_drop_pend, w_drop_pend_nxt;
    logic         w_need, w_emit, w_ptr_wr;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_free     = DEPTH_W - w_count;
    assign w_full     = (w_count == DEPTH_W);
    assign w_hd_valid = (w_count != '0);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_hd_first = w_head[129];
    assign w_hd_last  = w_head[128];
    assign w_hd_data  = w_head[127:0];

    // A pop in the same cycle frees a slot, so a push onto a full FIFO is still accepted.
    assign w_push = cell_wr & (~w_full | w_pop);
    assign w_drop = cell_wr & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {cell_first, cell_last, cell_din};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cell_bp <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_cell_bp <= (w_free < BP_W);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_left      <= '0;
            r_word_last <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_drop_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_left      <= w_left_nxt;
            r_word_last <= w_word_last_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_drop_pend <= w_drop_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_left_nxt      = r_left;
        w_word_last_nxt = r_word_last;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = r_err;
        w_drop_pend_nxt = r_drop_pend;
        w_need          = 1'b0;
        w_emit          = 1'b0;
        w_pop           = 1'b0;
        w_ptr_wr        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_drop) w_drop_pend_nxt = 1'b1;
                if (w_hd_valid) begin
                    w_pop = 1'b1;
                    if (w_hd_first) begin
                        // A word dropped now belongs to this frame or a later one.
                        w_len_nxt       = w_hd_data[10:0];
                        w_cnt_nxt       = '0;
                        w_err_nxt       = r_drop_pend | w_drop;
                        w_drop_pend_nxt = 1'b0;
                        w_left_nxt      = '0;
                        w_word_last_nxt = 1'b0;
                        if (w_hd_data[10:0] == 11'd0 || w_hd_data[10:0] > MAX_LEN_W) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = w_hd_last ? S_PTR : S_DRAIN;
                        end else begin
                            w_state_nxt = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (r_left != 5'd0) begin
                    if (!data_fifo_afull) begin
                        w_emit      = 1'b1;
                        w_cnt_nxt   = r_cnt + 11'd1;
                        w_shift_nxt = {r_shift[119:0], 8'h00};
                        w_left_nxt  = r_left - 5'd1;
                        if (r_cnt + 11'd1 == r_len) begin
                            w_state_nxt = r_word_last ? S_PTR : S_DRAIN;
                            if (!r_word_last) w_err_nxt = 1'b1;
                        end else if (r_left == 5'd1) begin
                            if (r_word_last) begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = S_PTR;
                            end else begin
                                w_need = 1'b1;
                            end
                        end
                    end
                end else begin
                    w_need = 1'b1;
                end
                // Reload in the cycle the last byte leaves so words stream without a bubble.
                if (w_need && w_hd_valid) begin
                    if (w_hd_first) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_PTR;
                    end else begin
                        w_pop           = 1'b1;
                        w_shift_nxt     = w_hd_data;
                        w_left_nxt      = 5'd16;
                        w_word_last_nxt = w_hd_last;
                    end
                end
                if (w_drop) w_err_nxt = 1'b1;
            end

            S_DRAIN: begin
                if (w_hd_valid) begin
                    if (w_hd_first) begin
                        w_state_nxt = S_PTR;
                    end else begin
                        w_pop = 1'b1;
                        if (w_hd_last) w_state_nxt = S_PTR;
                    end
                end
                if (w_drop) w_err_nxt = 1'b1;
            end

            S_PTR: begin
                if (w_drop) w_drop_pend_nxt = 1'b1;
                if (!ptr_fifo_full) begin
                    w_ptr_wr    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign cell_bp       = r_cell_bp;
    assign data_fifo_wr  = w_emit;
    assign data_fifo_din = r_shift[127:120];
    assign ptr_fifo_wr   = w_ptr_wr;
    assign ptr_fifo_din  = {r_err, 4'b0000, r_cnt};

`ifdef CELL_TO_FRAME_STATS_EN
    logic [31:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (w_ptr_wr) begin
            r_frame_cnt <= r_frame_cnt + 32'd1;
            if (r_err && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`else
    // statistics counters not built
`endif

endmodule

// File: tb/tb_cell_to_frame.sv
// Directed bench for cell_to_frame: frames, stalls, malformed frames and reset, with hand-computed descriptors.
module tb_cell_to_frame;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         cell_wr = 1'b0;
    logic [127:0] cell_din = '0;
    logic         cell_first = 1'b0;
    logic         cell_last = 1'b0;
    logic         cell_bp;
    logic [7:0]   data_fifo_din;
    logic         data_fifo_wr;
    logic         data_fifo_afull = 1'b0;
    logic [15:0]  ptr_fifo_din;
    logic         ptr_fifo_wr;
    logic         ptr_fifo_full = 1'b0;
`ifdef CELL_TO_FRAME_STATS_EN
    logic [31:0]  frame_cnt;
    logic [15:0]  err_cnt;
`endif

    cell_to_frame dut (
        .clk             (clk),
        .rstn            (rstn),
        .cell_wr         (cell_wr),
        .cell_din        (cell_din),
        .cell_first      (cell_first),
        .cell_last       (cell_last),
        .cell_bp         (cell_bp),
        .data_fifo_din   (data_fifo_din),
        .data_fifo_wr    (data_fifo_wr),
        .data_fifo_afull (data_fifo_afull),
        .ptr_fifo_din    (ptr_fifo_din),
        .ptr_fifo_wr     (ptr_fifo_wr),
        .ptr_fifo_full   (ptr_fifo_full)
`ifdef CELL_TO_FRAME_STATS_EN
        ,
        .frame_cnt       (frame_cnt),
        .err_cnt         (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hdr_k    = 0;
    int first_cyc, last_cyc, ptr_cyc, stall_wr;
    bit bp_seen;
    logic [7:0]  byte_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] ptr_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (data_fifo_wr) begin
                byte_q.push_back(data_fifo_din);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (data_fifo_afull) stall_wr++;
            end
            if (ptr_fifo_wr) begin
                ptr_q.push_back(ptr_fifo_din);
                ptr_cyc = cyc;
            end
            if (cell_bp) bp_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pay_byte(input int seed, input int k);
        return 8'((seed * 37 + k * 13 + (k >> 8)) & 255);
    endfunction

    function automatic logic [15:0] get_ptr(input int i);
        if (i < ptr_q.size()) return ptr_q[i];
        return 16'hxxxx;
    endfunction

    task automatic clear_mon();
        byte_q.delete();
        exp_q.delete();
        ptr_q.delete();
        first_cyc = -1;
        last_cyc  = -1;
        ptr_cyc   = -1;
        stall_wr  = 0;
        bp_seen   = 1'b0;
    endtask

    task automatic add_exp(input int seed, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(pay_byte(seed, k));
    endtask

    task automatic send_word(input bit f, input bit l, input logic [127:0] d);
        int g;
        g = 0;
        @(posedge clk); #1;
        while (cell_bp && g < 4000) begin
            cell_wr = 1'b0;
            g++;
            @(posedge clk); #1;
        end
        if (g >= 4000) chk("bp_wait", 32'd1, 32'd0);
        cell_wr    = 1'b1;
        cell_first = f;
        cell_last  = l;
        cell_din   = d;
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        cell_wr    = 1'b0;
        cell_first = 1'b0;
        cell_last  = 1'b0;
    endtask

    // last_w is the 1-based payload word carrying last (0 = none)
    task automatic send_frame(input int len, input int nw, input int last_w,
                              input bit hdr_last, input int seed);
        logic [127:0] w;
        w = '0;
        w[10:0] = 11'(len);
        send_word(1'b1, hdr_last, w);
        hdr_k = cyc + 1;
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < 16; b++) w[127 - 8*b -: 8] = pay_byte(seed, i*16 + b);
            send_word(1'b0, (i + 1) == last_w, w);
        end
        idle_in();
    endtask

    task automatic wait_ptr(input string tag, input int n, input int budget);
        int g;
        g = 0;
        while (ptr_q.size() < n && g < budget) begin
            @(posedge clk);
            g++;
        end
        if (ptr_q.size() < n) chk({tag, "_timeout"}, 32'(ptr_q.size()), 32'(n));
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_bytes(input int n, input int budget);
        int g;
        g = 0;
        while (byte_q.size() < n && g < budget) begin
            @(posedge clk); #1;
            g++;
        end
        if (byte_q.size() < n) chk("byte_timeout", 32'(byte_q.size()), 32'(n));
    endtask

    task automatic check_bytes(input string tag);
        int bad;
        bad = 0;
        chk({tag, "_nbytes"}, 32'(byte_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < byte_q.size() && i < exp_q.size(); i++)
            if (byte_q[i] !== exp_q[i]) bad++;
        chk({tag, "_order"}, 32'(bad), 32'd0);
    endtask

    initial begin
        clear_mon();
        repeat (3) @(posedge clk); #1;
        chk("rst_bp", 32'(cell_bp), 32'd0);
        chk("rst_dwr", 32'(data_fifo_wr), 32'd0);
        chk("rst_pwr", 32'(ptr_fifo_wr), 32'd0);
        chk("rst_pdin", 32'(ptr_fifo_din), 32'd0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // 62-byte frame, latency and descriptor timing
        clear_mon();
        send_frame(62, 4, 4, 1'b0, 1);
        add_exp(1, 62);
        wait_ptr("t1", 1, 500);
        chk("t1_ptr", 32'(get_ptr(0)), 32'h003E);
        chk("t1_nptr", 32'(ptr_q.size()), 32'd1);
        check_bytes("t1");
        chk("t1_lat", 32'(first_cyc - hdr_k), 32'd2);
        chk("t1_ptrlat", 32'(ptr_cyc - last_cyc), 32'd1);

        // 1514-byte frame, back-to-back words with backpressure
        clear_mon();
        send_frame(1514, 95, 95, 1'b0, 2);
        add_exp(2, 1514);
        wait_ptr("t2", 1, 3000);
        chk("t2_ptr", 32'(get_ptr(0)), 32'h05EA);
        check_bytes("t2");
        chk("t2_bp_seen", 32'(bp_seen), 32'd1);
        chk("t2_bp_end", 32'(cell_bp), 32'd0);

        // byte FIFO stall mid-frame
        clear_mon();
        fork
            send_frame(48, 3, 3, 1'b0, 3);
            begin
                wait_bytes(10, 300);
                data_fifo_afull = 1'b1;
                repeat (20) @(posedge clk);
                #1 data_fifo_afull = 1'b0;
            end
        join
        add_exp(3, 48);
        wait_ptr("t3", 1, 500);
        chk("t3_ptr", 32'(get_ptr(0)), 32'h0030);
        chk("t3_stall_wr", 32'(stall_wr), 32'd0);
        check_bytes("t3");

        // descriptor FIFO full holds the descriptor
        clear_mon();
        ptr_fifo_full = 1'b1;
        send_frame(16, 1, 1, 1'b0, 4);
        wait_bytes(16, 300);
        repeat (30) @(posedge clk); #1;
        chk("t4_held", 32'(ptr_q.size()), 32'd0);
        chk("t4_pwr_held", 32'(ptr_fifo_wr), 32'd0);
        ptr_fifo_full = 1'b0;
        wait_ptr("t4", 1, 50);
        chk("t4_ptr", 32'(get_ptr(0)), 32'h0010);
        chk("t4_nptr", 32'(ptr_q.size()), 32'd1);
        add_exp(4, 16);
        check_bytes("t4");

        // last word arrives before len bytes
        clear_mon();
        send_frame(100, 4, 4, 1'b0, 5);
        add_exp(5, 64);
        wait_ptr("t5", 1, 500);
        chk("t5_ptr", 32'(get_ptr(0)), 32'h8040);
        check_bytes("t5");

        // len reached before the last word
        clear_mon();
        send_frame(20, 3, 3, 1'b0, 6);
        add_exp(6, 20);
        wait_ptr("t6", 1, 500);
        chk("t6_ptr", 32'(get_ptr(0)), 32'h8014);
        check_bytes("t6");

        // orphan payload word
        clear_mon();
        send_word(1'b0, 1'b1, {4{32'hA5A5_5A5A}});
        idle_in();
        repeat (30) @(posedge clk);
        chk("t7_bytes", 32'(byte_q.size()), 32'd0);
        chk("t7_ptrs", 32'(ptr_q.size()), 32'd0);

        // zero-length header
        clear_mon();
        send_frame(0, 0, 0, 1'b1, 0);
        wait_ptr("t8", 1, 100);
        chk("t8_ptr", 32'(get_ptr(0)), 32'h8000);
        chk("t8_bytes", 32'(byte_q.size()), 32'd0);

        // new header arrives mid-frame
        clear_mon();
        send_frame(64, 2, 0, 1'b0, 7);
        send_frame(32, 2, 2, 1'b0, 8);
        add_exp(7, 32);
        add_exp(8, 32);
        wait_ptr("t9", 2, 1000);
        chk("t9_ptr0", 32'(get_ptr(0)), 32'h8020);
        chk("t9_ptr1", 32'(get_ptr(1)), 32'h0020);
        check_bytes("t9");

`ifdef CELL_TO_FRAME_STATS_EN
        chk("stats_frames", frame_cnt, 32'd9);
        chk("stats_errs", 32'(err_cnt), 32'd4);
`endif

        // reset mid-frame
        clear_mon();
        send_frame(64, 2, 0, 1'b0, 10);
        wait_bytes(10, 300);
        rstn = 1'b0;
        #1;
        chk("t10_dwr", 32'(data_fifo_wr), 32'd0);
        chk("t10_din", 32'(data_fifo_din), 32'd0);
        chk("t10_pwr", 32'(ptr_fifo_wr), 32'd0);
        chk("t10_bp", 32'(cell_bp), 32'd0);
        repeat (3) @(posedge clk); #1;
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        chk("t10_no_ptr", 32'(ptr_q.size()), 32'd0);
        clear_mon();
        send_frame(30, 2, 2, 1'b0, 9);
        add_exp(9, 30);
        wait_ptr("t10", 1, 500);
        chk("t10_ptr", 32'(get_ptr(0)), 32'h001E);
        check_bytes("t10");

`ifdef CELL_TO_FRAME_STATS_EN
        chk("stats_frames_rst", frame_cnt, 32'd1);
        chk("stats_errs_rst", 32'(err_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
